// File: rtl/ibf_insert_scheduler_pkg.sv
// Shared widths, IBF target-bit positions and FSM encoding for the IBF insert scheduler.
package ibf_insert_scheduler_pkg;

  localparam int unsigned KeyField = 32;
  localparam int unsigned SetLen   = 16;

  // Bit positions inside a 2-bit target / write-enable vector.
  localparam int unsigned TgtIbf1 = 0;
  localparam int unsigned TgtIbf2 = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/ibf_insert_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; masked requesters are never granted.
module ibf_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       last_q;
  logic [1:0] elig;

  assign elig = req & ~mask;

  always_comb begin
    grant = elig;
    if (&elig) grant = last_q ? 2'b01 : 2'b10;
  end

  // last_q = 1 means src1 was served last, so reset leaves src0 favoured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/ibf_insert_scheduler.sv
// Sequences keys from two sources into the shared CRC/IBF datapath.
// Optional WAIT watchdog enabled by defining IBF_TIMEOUT_EN.
module ibf_insert_scheduler
  import ibf_insert_scheduler_pkg::*;
#(
  parameter int unsigned KEY_W       = KeyField,
  parameter int unsigned CNT_W       = SetLen,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_valid,
  input  logic [KEY_W-1:0] s0_key,
  input  logic [1:0]       s0_tgt,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [KEY_W-1:0] s1_key,
  input  logic [1:0]       s1_tgt,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic             dp_start,
  output logic [KEY_W-1:0] dp_key,
  output logic [1:0]       dp_sel,
  input  logic             dp_done,
  input  logic             restart,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_ibf1,
  output logic [CNT_W-1:0] cnt_ibf2,
  output logic             insert_done,
  output logic             err_timeout
);

  state_e             state_q, state_d;
  logic [1:0]         grant, accept, fin_q, fin_d;
  logic               hs, wait_end, timeout, last_q, src_q;
  logic [KEY_W-1:0]   key_q;
  logic [1:0]         sel_q;
  logic [CNT_W-1:0]   cnt1_q, cnt2_q;

  ibf_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({s1_valid, s0_valid}),
    .mask    (fin_q),
    .advance (hs),
    .grant   (grant)
  );

  assign accept   = {s1_valid & s1_ready, s0_valid & s0_ready};
  assign hs       = |accept;
  assign wait_end = (state_q == StWait) & (dp_done | timeout);

`ifdef IBF_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_q;
  logic            err_q;

  // Fires on the last permitted WAIT cycle if the datapath is still silent.
  assign timeout = (state_q == StWait) & ~dp_done & (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == StWait) ? tmo_q + TmoW'(1) : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Finish flags; a dropped (timed-out) key still honours its last flag.
  always_comb begin
    fin_d = fin_q;
    if (wait_end && last_q) fin_d[src_q] = 1'b1;
    if (state_q == StDone && restart) fin_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (wait_end) state_d = (&fin_d) ? StDone : StIdle;
      StDone:  if (restart) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dp_start    = (state_q == StIssue);
    busy        = (state_q == StIssue) | (state_q == StWait);
    insert_done = (state_q == StDone);
    s0_ready    = (state_q == StIdle) & grant[0];
    s1_ready    = (state_q == StIdle) & grant[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q  <= '0;
      sel_q  <= '0;
      last_q <= 1'b0;
      src_q  <= 1'b0;
      fin_q  <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      fin_q <= fin_d;
      if (hs) begin
        key_q  <= accept[1] ? s1_key  : s0_key;
        sel_q  <= accept[1] ? s1_tgt  : s0_tgt;
        last_q <= accept[1] ? s1_last : s0_last;
        src_q  <= accept[1];
      end
      if (state_q == StWait && dp_done) begin
        if (sel_q[TgtIbf1] && cnt1_q != '1) cnt1_q <= cnt1_q + CNT_W'(1);
        if (sel_q[TgtIbf2] && cnt2_q != '1) cnt2_q <= cnt2_q + CNT_W'(1);
      end
      if (state_q == StDone && restart) begin
        cnt1_q <= '0;
        cnt2_q <= '0;
      end
    end
  end

  assign dp_key   = key_q;
  assign dp_sel   = sel_q;
  assign cnt_ibf1 = cnt1_q;
  assign cnt_ibf2 = cnt2_q;

endmodule
